quadrature_decoder: RTL and testbench
=====================================

// Module: quadrature_decoder
//
// PURPOSE
//   Decodes a 2-phase quadrature input pair (A/B) into one-cycle step pulses with
//   a direction flag. Drives a WIDTH-bit wrapping position counter from those pulses.
//   Sits upstream of a counter: generates the enable/up_down command stream from
//   asynchronous encoder pins. Includes input synchroniser, glitch filter and an
//   illegal-transition detector.
//
// PARAMETERS
//   WIDTH       4   position counter width; count wraps modulo 2**WIDTH
//   FILTER_LEN  2   consecutive stable samples required to accept new A/B (>=1)
//
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous, active-high reset
//   a_in     in   1      phase A, asynchronous to clk
//   b_in     in   1      phase B, asynchronous to clk
//   enable   in   1      1: steps update count; 0: count holds (steps still flagged)
//   clr      in   1      synchronous clear of count and err
//   step     out  1      one-cycle pulse per accepted legal transition
//   dir      out  1      direction of last step: 1 = up, 0 = down
//   err      out  1      sticky: illegal transition seen (both bits changed)
//   count    out  WIDTH  position counter
//
// BEHAVIOUR
//   - Reset values: step=0, dir=0, err=0, count=0. Sync flops=00, filtered state ab_f=00.
//     primed=0.
//   - Sync: a_in/b_in each pass through a 2-flop synchroniser -> ab_s = {a_s,b_s}.
//   - Filter: ab_s is accepted into ab_f at the edge where ab_s != ab_f and ab_s has
//     held the same value for FILTER_LEN consecutive edges. Any change restarts the count.
//   - Prime: the first acceptance after rst loads ab_f silently (no step, no err).
//     primed<=1 at that edge.
//   - Decode (primed=1), at the acceptance edge, {ab_f,new}:
//       up:      00->01, 01->11, 11->10, 10->00     -> step=1 next cycle, dir=1
//       down:    reverse of the above               -> step=1 next cycle, dir=0
//       illegal: both bits differ (00<->11, 01<->10) -> err<=1, no step, dir holds
//   - step is high exactly one cycle per accepted legal transition. dir is registered
//     with step and holds between steps.
//   - Latency: A/B edge (stable) -> step high after 2 + FILTER_LEN clk edges;
//     count updates on the edge after step.
//   - Count: on step & enable, count +/- 1, wrapping: F+1->0, 0-1->F (WIDTH=4).
//     enable=0: count holds.
//   - clr=1: count<=0, err<=0. Takes priority over a same-cycle count update.
//     Decode/filter are unaffected.
//   - rst mid-operation: all state returns to reset values, primed=0.
//     A pending step is dropped.
//   - Max legal input rate: one A/B change per (FILTER_LEN+1) clk cycles.
//     Faster changes are filtered.
//
// STRUCTURE
//   - quad_defs.vh (shared include): AB state encodings QD_S00..QD_S11, QD_UP/QD_DN
//     direction constants.
//   - Sub-module quad_input_filter: 2-flop sync + FILTER_LEN stability filter on a
//     2-bit bus. Outputs ab_f and a one-cycle 'accept' strobe.
//   - Top: prime flag, transition decode, step/dir/err regs, position counter.
//
// TESTING (WIDTH=4, FILTER_LEN=2; hold each input value >= 6 cycles)
//   1. rst=1 for 2 cycles, A/B=00 -> count=0, step=0, err=0, dir=0.
//      After release and prime: no step.
//   2. Up sequence 00->01->11->10->00, enable=1 -> 4 step pulses with dir=1, count=4.
//      Then reverse 00->10->11 -> 2 pulses with dir=0, count=2.
//   3. 1-cycle glitch on a_in -> no step, ab_f unchanged, count unchanged.
//   4. Step 00->11 -> err=1 (sticky), no step, count unchanged.
//      clr pulse -> err=0, count=0.
//   5. Wrap: from count=F one up step -> 0; then one down step -> F.
//      enable=0 during 2 up steps -> step pulses, count stays F.
//   6. clr asserted in the cycle count would increment -> count=0.
//      rst mid-sequence -> outputs 0, and the next accepted A/B value only primes.

Source files
------------

// File: rtl/quadrature_decoder_pkg.sv
// Shared A/B phase encodings, direction constants and the forward-rotation helper.
package quadrature_decoder_pkg;

    localparam logic [1:0] QD_S00 = 2'b00;
    localparam logic [1:0] QD_S01 = 2'b01;
    localparam logic [1:0] QD_S11 = 2'b11;
    localparam logic [1:0] QD_S10 = 2'b10;

    localparam logic QD_UP = 1'b1;
    localparam logic QD_DN = 1'b0;

    // Next state when rotating in the up direction: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] qd_next_up(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            QD_S00:  nxt = QD_S01;
            QD_S01:  nxt = QD_S11;
            QD_S11:  nxt = QD_S10;
            default: nxt = QD_S00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quadrature_decoder_filter.sv
// Two-flop synchroniser plus stability filter on the 2-bit A/B bus.
// o_ab_f is the accepted value, o_ab_prev the value it replaced, o_accept a
// one-cycle strobe in the cycle after each acceptance.
module quadrature_decoder_filter #(
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_ab,
    output logic [1:0] o_ab_f,
    output logic [1:0] o_ab_prev,
    output logic       o_accept
);
    import quadrature_decoder_pkg::*;

    localparam int unsigned CW = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);

    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_ab_f;
    logic [1:0]    r_ab_prev;
    logic          r_accept;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_accept;

    // Stability run length of the value landing in the second sync flop this edge.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_s1 != r_s2) begin
            w_cnt_next = CW'(1);
        end else if (r_cnt < CW'(FILTER_LEN)) begin
            w_cnt_next = r_cnt + CW'(1);
        end
        w_accept = (w_cnt_next >= CW'(FILTER_LEN)) && (r_s1 != r_ab_f);
    end

    // Synchroniser, run counter and accepted-value registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= QD_S00;
            r_s2      <= QD_S00;
            r_cnt     <= '0;
            r_ab_f    <= QD_S00;
            r_ab_prev <= QD_S00;
            r_accept  <= 1'b0;
        end else begin
            r_s1     <= i_ab;
            r_s2     <= r_s1;
            r_cnt    <= w_cnt_next;
            r_accept <= w_accept;
            if (w_accept) begin
                r_ab_prev <= r_ab_f;
                r_ab_f    <= r_s1;
            end
        end
    end

    assign o_ab_f    = r_ab_f;
    assign o_ab_prev = r_ab_prev;
    assign o_accept  = r_accept;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B -> step/dir pulses, sticky illegal-transition
// flag and a wrapping position counter.
module quadrature_decoder #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             enable,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [WIDTH-1:0] count
);
    import quadrature_decoder_pkg::*;

    logic [1:0]       w_ab_f;
    logic [1:0]       w_ab_prev;
    logic             w_accept;
    logic             w_up;
    logic             w_dn;
    logic             w_illegal;

    logic             r_primed;
    logic             r_step;
    logic             r_dir;
    logic             r_err;
    logic [WIDTH-1:0] r_count;

    quadrature_decoder_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .i_ab      ({a_in, b_in}),
        .o_ab_f    (w_ab_f),
        .o_ab_prev (w_ab_prev),
        .o_accept  (w_accept)
    );

    // Classify the transition just accepted by the filter.
    always_comb begin
        w_up      = (w_ab_f == qd_next_up(w_ab_prev));
        w_dn      = (w_ab_prev == qd_next_up(w_ab_f));
        w_illegal = ((w_ab_f ^ w_ab_prev) == 2'b11);
    end

    // Prime flag, step/dir/err registers and position counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_primed <= 1'b0;
            r_step   <= 1'b0;
            r_dir    <= QD_DN;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_step <= 1'b0;
            if (w_accept) begin
                if (!r_primed) begin
                    r_primed <= 1'b1;
                end else if (w_up || w_dn) begin
                    r_step <= 1'b1;
                    r_dir  <= w_up ? QD_UP : QD_DN;
                end else if (w_illegal) begin
                    r_err <= 1'b1;
                end
            end
            // clr overrides both the counter update and a same-cycle error set.
            if (clr) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (r_step && enable) begin
                r_count <= (r_dir == QD_UP) ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
            end
        end
    end

    assign step  = r_step;
    assign dir   = r_dir;
    assign err   = r_err;
    assign count = r_count;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed, table-driven bench for quadrature_decoder (WIDTH=4, FILTER_LEN=2).
module tb_quadrature_decoder;

    logic       clk;
    logic       rst;
    logic       a_in;
    logic       b_in;
    logic       enable;
    logic       clr;
    logic       step;
    logic       dir;
    logic       err;
    logic [3:0] count;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [1:0] ab;
        logic       en;
        int         steps;
        logic       dir;
        logic [3:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    quadrature_decoder #(
        .WIDTH      (4),
        .FILTER_LEN (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a_in   (a_in),
        .b_in   (b_in),
        .enable (enable),
        .clr    (clr),
        .step   (step),
        .dir    (dir),
        .err    (err),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hold current inputs for n cycles, counting cycles with step high.
    task automatic window(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (step) pulses++;
        end
    endtask

    initial begin
        int p;
        int waited;
        bit seen;

        n_cmp = 0;
        n_bad = 0;

        // ab, en, steps, dir, count, err
        vecs[0]  = '{2'b01, 1'b1, 0, 1'b0, 4'd0,  1'b0}; // prime only
        vecs[1]  = '{2'b11, 1'b1, 1, 1'b1, 4'd1,  1'b0};
        vecs[2]  = '{2'b10, 1'b1, 1, 1'b1, 4'd2,  1'b0};
        vecs[3]  = '{2'b00, 1'b1, 1, 1'b1, 4'd3,  1'b0};
        vecs[4]  = '{2'b01, 1'b1, 1, 1'b1, 4'd4,  1'b0};
        vecs[5]  = '{2'b00, 1'b1, 1, 1'b0, 4'd3,  1'b0};
        vecs[6]  = '{2'b10, 1'b1, 1, 1'b0, 4'd2,  1'b0};
        vecs[7]  = '{2'b01, 1'b1, 0, 1'b0, 4'd2,  1'b1}; // illegal 10->01
        vecs[8]  = '{2'b00, 1'b1, 1, 1'b0, 4'd15, 1'b0}; // 0-1 wraps (after clr)
        vecs[9]  = '{2'b01, 1'b1, 1, 1'b1, 4'd0,  1'b0}; // F+1 wraps
        vecs[10] = '{2'b00, 1'b1, 1, 1'b0, 4'd15, 1'b0};
        vecs[11] = '{2'b01, 1'b0, 1, 1'b1, 4'd15, 1'b0}; // enable=0 holds
        vecs[12] = '{2'b11, 1'b0, 1, 1'b1, 4'd15, 1'b0};
        vecs[13] = '{2'b10, 1'b1, 1, 1'b1, 4'd0,  1'b0};

        // Reset with A/B idle.
        rst = 1'b1; a_in = 1'b0; b_in = 1'b0; enable = 1'b1; clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_count", int'(count), 0);
        check("reset_step",  int'(step),  0);
        check("reset_err",   int'(err),   0);
        check("reset_dir",   int'(dir),   0);

        for (int v = 0; v < 14; v++) begin
            {a_in, b_in} = vecs[v].ab;
            enable = vecs[v].en;
            window(8, p);
            check($sformatf("v%0d_steps", v), p, vecs[v].steps);
            check($sformatf("v%0d_dir", v),   int'(dir),   int'(vecs[v].dir));
            check($sformatf("v%0d_count", v), int'(count), int'(vecs[v].cnt));
            check($sformatf("v%0d_err", v),   int'(err),   int'(vecs[v].err));

            // Glitch test while sitting at 10 with count=2.
            if (v == 6) begin
                a_in = 1'b0;
                @(negedge clk);
                a_in = 1'b1;
                window(8, p);
                check("glitch_steps", p, 0);
                check("glitch_count", int'(count), 2);
            end
            // Clear the sticky error and count.
            if (v == 7) begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                @(negedge clk);
                check("clr_err",   int'(err),   0);
                check("clr_count", int'(count), 0);
            end
        end

        // clr in the cycle the count would increment (now at 10, count 0).
        {a_in, b_in} = 2'b00;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 20) begin
            @(negedge clk);
            waited++;
            if (step) seen = 1'b1;
        end
        check("clrstep_seen", int'(seen), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        window(4, p);
        check("clrstep_count", int'(count), 0);

        // One more up step, then reset with a step pending.
        {a_in, b_in} = 2'b01;
        window(8, p);
        check("prerst_count", int'(count), 1);
        check("prerst_dir",   int'(dir),   1);
        {a_in, b_in} = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        window(8, p);
        check("rst_steps", p, 0);
        check("rst_count", int'(count), 0);
        check("rst_dir",   int'(dir),   0);
        check("rst_err",   int'(err),   0);
        {a_in, b_in} = 2'b10;
        window(8, p);
        check("postrst_steps", p, 1);
        check("postrst_count", int'(count), 1);
        check("postrst_dir",   int'(dir),   1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
